// File: rtl/mem_snoop_arbiter.sv
// Round-robin arbiter that funnels N cache request ports onto one memory port.
// It broadcasts one snoop per grant and aborts a memory wait with an error flag on timeout.
module mem_snoop_arbiter #(
    parameter int NUM_CORES    = 4,
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int CORE_W       = $clog2(NUM_CORES),
    parameter int RESP_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req_valid,
    output logic [NUM_CORES-1:0]        req_ready,
    input  logic [NUM_CORES-1:0]        req_we,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    output logic [NUM_CORES-1:0]        resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        resp_err,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_req_we,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [DATA_W-1:0]           mem_req_write,
    input  logic                        mem_resp_valid,
    input  logic [DATA_W-1:0]           mem_resp_data,
    output logic                        snoop_valid,
    output logic [CORE_W-1:0]           snoop_core,
    output logic                        snoop_cmd,
    output logic [ADDR_W-1:0]           snoop_addr
);

    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SNOOP, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [CORE_W-1:0]  last_grant;
    logic [CORE_W-1:0]  grant_q;
    logic [CORE_W-1:0]  grant_idx;
    logic               grant_found;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  data_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               timeout_hit;

    // The abort fires on the last permitted WAIT cycle, so WAIT lasts RESP_TIMEOUT cycles.
    assign timeout_hit = (cnt_q == CNT_W'(RESP_TIMEOUT - 1));

    always_comb begin
        int                idx;
        logic [CORE_W-1:0] cand;
        idx         = 0;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            cand = CORE_W'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (grant_found) state_next = SNOOP;
            SNOOP: state_next = ISSUE;
            ISSUE: if (mem_req_ready) state_next = mem_resp_valid ? RESP : WAIT;
            WAIT:  if (mem_resp_valid || timeout_hit) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        resp_valid    = '0;
        resp_data     = '0;
        resp_err      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_write = '0;
        snoop_valid   = 1'b0;
        snoop_core    = '0;
        snoop_cmd     = 1'b0;
        snoop_addr    = '0;
        case (state)
            // Gated by rst_n so no core sees an accept while the block is held in reset.
            IDLE: if (grant_found && rst_n) req_ready[grant_idx] = 1'b1;
            SNOOP: begin
                snoop_valid = 1'b1;
                snoop_core  = grant_q;
                snoop_cmd   = we_q;
                snoop_addr  = addr_q;
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_we    = we_q;
                mem_req_addr  = addr_q;
                mem_req_write = wdata_q;
            end
            RESP: begin
                resp_valid[grant_q] = 1'b1;
                resp_data           = data_q;
                resp_err            = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= CORE_W'(NUM_CORES - 1);
            grant_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state)
                IDLE: if (grant_found) begin
                    grant_q <= grant_idx;
                    we_q    <= req_we[grant_idx];
                    addr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                    wdata_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
                end
                ISSUE: if (mem_req_ready) begin
                    if (mem_resp_valid) begin
                        data_q <= mem_resp_data;
                        err_q  <= 1'b0;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        data_q <= mem_resp_data;
                        err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: last_grant <= grant_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_snoop_arbiter.sv
// Self-checking bench for mem_snoop_arbiter.
// It pairs directed and randomized transactions with a round-robin and memory-timing model.
module tb_mem_snoop_arbiter;

    localparam int N      = 4;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int CORE_W = $clog2(N);
    localparam int RT     = 255;

    logic                     clk;
    logic                     rst_n;
    logic [N-1:0]             req_valid;
    logic [N-1:0]             req_ready;
    logic [N-1:0]             req_we;
    logic [N*ADDR_W-1:0]      req_addr;
    logic [N*DATA_W-1:0]      req_wdata;
    logic [N-1:0]             resp_valid;
    logic [DATA_W-1:0]        resp_data;
    logic                     resp_err;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_we;
    logic [ADDR_W-1:0]        mem_req_addr;
    logic [DATA_W-1:0]        mem_req_write;
    logic                     mem_resp_valid;
    logic [DATA_W-1:0]        mem_resp_data;
    logic                     snoop_valid;
    logic [CORE_W-1:0]        snoop_core;
    logic                     snoop_cmd;
    logic [ADDR_W-1:0]        snoop_addr;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]             vld;
    logic                     we_a    [N];
    logic [ADDR_W-1:0]        addr_a  [N];
    logic [DATA_W-1:0]        wdata_a [N];
    int                       last_grant_m;

    mem_snoop_arbiter #(
        .NUM_CORES(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CORE_W(CORE_W), .RESP_TIMEOUT(RT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .snoop_valid(snoop_valid), .snoop_core(snoop_core), .snoop_cmd(snoop_cmd),
        .snoop_addr(snoop_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v);
        vld       = v;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_we[i]                    = we_a[i];
            req_addr[i*ADDR_W +: ADDR_W] = addr_a[i];
            req_wdata[i*DATA_W +: DATA_W] = wdata_a[i];
        end
    endtask

    // Fair arbitration: the first requester strictly after the previous winner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    task automatic randomize_cores();
        for (int i = 0; i < N; i++) begin
            we_a[i]    = 1'($urandom_range(0, 1));
            addr_a[i]  = ADDR_W'($urandom);
            wdata_a[i] = DATA_W'($urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_req_ready"},     32'(req_ready),     32'd0);
        checkOutput({tag, "_resp_valid"},    32'(resp_valid),    32'd0);
        checkOutput({tag, "_resp_data"},     32'(resp_data),     32'd0);
        checkOutput({tag, "_resp_err"},      32'(resp_err),      32'd0);
        checkOutput({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        checkOutput({tag, "_mem_req_addr"},  32'(mem_req_addr),  32'd0);
        checkOutput({tag, "_snoop_valid"},   32'(snoop_valid),   32'd0);
        checkOutput({tag, "_snoop_addr"},    32'(snoop_addr),    32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus('0);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        last_grant_m = N - 1;
    endtask

    // Called at a negedge with requests applied. resp_delay<0 means memory never answers;
    // abort_after>0 returns mid-WAIT after that many WAIT cycles.
    task automatic run_txn(input int ready_delay, input int resp_delay,
                           input logic [DATA_W-1:0] rdata, input int abort_after);
        int g;
        int wait_cycles;
        logic [DATA_W-1:0] exp_data;
        logic exp_err;
        g = rr_pick(vld, last_grant_m);
        #1;
        checkOutput("req_ready", 32'(req_ready), 32'(1) << g);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = DATA_W'($urandom);
        #1;
        checkOutput("req_ready_low", 32'(req_ready),   32'd0);
        checkOutput("snoop_valid",   32'(snoop_valid), 32'd1);
        checkOutput("snoop_core",    32'(snoop_core),  32'(g));
        checkOutput("snoop_cmd",     32'(snoop_cmd),   32'(we_a[g]));
        checkOutput("snoop_addr",    32'(snoop_addr),  32'(addr_a[g]));
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < ready_delay; i++) begin
            mem_req_ready = 1'b0;
            #1;
            checkOutput("mem_req_valid_hold", 32'(mem_req_valid), 32'd1);
            checkOutput("mem_req_addr_hold",  32'(mem_req_addr),  32'(addr_a[g]));
            checkOutput("snoop_valid_low",    32'(snoop_valid),   32'd0);
            @(negedge clk);
        end
        mem_req_ready  = 1'b1;
        mem_resp_valid = (resp_delay == 0);
        mem_resp_data  = rdata;
        #1;
        checkOutput("mem_req_valid", 32'(mem_req_valid), 32'd1);
        checkOutput("mem_req_we",    32'(mem_req_we),    32'(we_a[g]));
        checkOutput("mem_req_addr",  32'(mem_req_addr),  32'(addr_a[g]));
        checkOutput("mem_req_write", 32'(mem_req_write), 32'(wdata_a[g]));
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = DATA_W'($urandom);
        exp_data       = rdata;
        exp_err        = 1'b0;
        if (resp_delay != 0) begin
            wait_cycles = (resp_delay < 0) ? RT : resp_delay;
            for (int w = 1; w <= wait_cycles; w++) begin
                #1;
                checkOutput("wait_mem_req_valid", 32'(mem_req_valid), 32'd0);
                checkOutput("wait_resp_valid",    32'(resp_valid),    32'd0);
                if (w == abort_after) return;
                if (w == resp_delay) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = rdata;
                end
                @(negedge clk);
                mem_resp_valid = 1'b0;
                mem_resp_data  = DATA_W'($urandom);
            end
            if (resp_delay < 0) begin
                exp_data = '0;
                exp_err  = 1'b1;
            end
        end
        #1;
        checkOutput("resp_valid",       32'(resp_valid),    32'(1) << g);
        checkOutput("resp_data",        32'(resp_data),     32'(exp_data));
        checkOutput("resp_err",         32'(resp_err),      32'(exp_err));
        checkOutput("resp_mem_req_low", 32'(mem_req_valid), 32'd0);
        last_grant_m = g;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_resp_data = '0;
        for (int i = 0; i < N; i++) begin
            we_a[i]    = 1'b0;
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end
        @(negedge clk);
        do_reset();

        $display("[TB] single read from core 2");
        addr_a[2] = 11'h155;
        we_a[2]   = 1'b0;
        applyStimulus(4'b0100);
        run_txn(0, 2, 8'hA5, 0);

        $display("[TB] RFO write from core 1 with stalled memory");
        we_a[1]    = 1'b1;
        addr_a[1]  = 11'h7FF;
        wdata_a[1] = 8'h3C;
        applyStimulus(4'b0010);
        run_txn(3, 1, DATA_W'($urandom), 0);

        $display("[TB] round-robin with all cores requesting");
        do_reset();
        randomize_cores();
        applyStimulus(4'b1111);
        for (int t = 0; t < 5; t++)
            run_txn($urandom_range(0, 2), $urandom_range(0, 3), DATA_W'($urandom), 0);

        $display("[TB] same-cycle accept and response");
        randomize_cores();
        applyStimulus(4'b1000);
        run_txn(0, 0, 8'h5A, 0);

        $display("[TB] response timeout then normal request");
        randomize_cores();
        applyStimulus(4'b0001);
        run_txn(0, -1, 8'hFF, 0);
        applyStimulus(4'b0100);
        run_txn(0, 1, DATA_W'($urandom), 0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 12; t++) begin
            randomize_cores();
            applyStimulus(N'($urandom_range(1, (1 << N) - 1)));
            run_txn($urandom_range(0, 3), $urandom_range(0, 4), DATA_W'($urandom), 0);
        end

        $display("[TB] async reset during WAIT");
        randomize_cores();
        applyStimulus(4'b0010);
        run_txn(0, -1, 8'h00, 5);
        #2;
        rst_n = 1'b0;
        applyStimulus(4'b1001);
        #1;
        check_all_zero("mid_reset");
        repeat (2) begin
            @(negedge clk);
            #1;
            check_all_zero("held_reset");
        end
        @(negedge clk);
        rst_n        = 1'b1;
        last_grant_m = N - 1;
        run_txn(1, 2, DATA_W'($urandom), 0);
        run_txn(0, 0, DATA_W'($urandom), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_snoop_arbiter.md
Name: mem_snoop_arbiter

Overview:
- Parametrised N-core successor to the single cache-to-memory request path.
- Arbitrates N cache miss/writeback requests (cache_mem_if-style handshake per core) onto one main-memory port.
- Round-robin fairness; broadcasts one snoop per granted transaction; response timeout with error flag.
- Sits between the per-core caches and main memory; drives the shared snoop bus.

Parameters:
NUM_CORES, 4, number of requesting caches (2..8)
ADDR_W, 11, address width
DATA_W, 8, data width (byte)
CORE_W, $clog2(NUM_CORES), core-ID width for snoop_core
RESP_TIMEOUT, 255, max cycles in WAIT before abort (8-bit counter)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_CORES  per-core request pending
req_ready  out  NUM_CORES  per-core request accepted (one-hot or zero)
req_we  in  NUM_CORES  per-core 0=read, 1=write
req_addr  in  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_CORES*DATA_W  per-core write byte, same packing
resp_valid  out  NUM_CORES  per-core response strobe (one-hot or zero)
resp_data  out  DATA_W  shared response byte, valid with resp_valid
resp_err  out  1  timeout flag, valid with resp_valid
mem_req_valid  out  1  memory request pending
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  0=read, 1=write
mem_req_addr  out  ADDR_W  memory address
mem_req_write  out  DATA_W  memory write byte
mem_resp_valid  in  1  memory response/done
mem_resp_data  in  DATA_W  memory read byte
snoop_valid  out  1  snoop broadcast this cycle
snoop_core  out  CORE_W  initiating core
snoop_cmd  out  1  0=Read, 1=RFO (equals latched we)
snoop_addr  out  ADDR_W  snooped address

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; last_grant=NUM_CORES-1, so core 0 has first priority; timeout counter 0. Reset mid-transaction abandons it silently. No resp_valid is issued.
- States: IDLE -> SNOOP -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any req_valid, winner g = first set bit scanning from (last_grant+1) mod NUM_CORES upward with wrap.
  - req_ready[g]=1 combinationally that cycle; transfer occurs on that edge.
  - Latch g, we, addr, wdata; go to SNOOP. Otherwise stay in IDLE; req_ready=0.
- SNOOP (1 cycle): snoop_valid=1, snoop_core=g, snoop_cmd=we, snoop_addr=addr; go to ISSUE.
- ISSUE: mem_req_valid=1 with latched we/addr/wdata, held stable until mem_req_ready=1.
  - On accept with mem_resp_valid=1 in the same cycle: capture mem_resp_data, go to RESP.
  - On accept alone: go to WAIT, clear counter.
- WAIT: mem_req_valid=0.
  - On mem_resp_valid: capture data, err=0, go to RESP.
  - Otherwise increment counter. When counter reaches RESP_TIMEOUT without a response: data=0, err=1, go to RESP.
- RESP (1 cycle): resp_valid[g]=1, resp_data=captured byte, resp_err=err; last_grant<=g; go to IDLE.
  - Earliest re-grant is the next cycle.
- Writes return resp_data = mem_resp_data as driven by memory (don't-care to caches).
- mem_resp_valid outside ISSUE/WAIT is ignored.
- Minimum latency from request accept to resp_valid: 3 cycles (SNOOP, ISSUE with same-cycle response, RESP).
- Only one transaction is outstanding at a time. req_ready and resp_valid are never asserted for more than one core in a cycle.
- All outputs other than req_ready are registered or decoded from state/latched fields only (no input-to-output combinational paths except req_ready).

Test Plan:
- Reset then single read: core 2 req addr=0x155, memory ready=1, resp after 2 cycles with 0xA5 -> req_ready[2] pulse; snoop (core=2, cmd=0, addr=0x155) next cycle; resp_valid[2] with 0xA5, err=0.
- Write RFO: core 1 we=1, addr=0x7FF, wdata=0x3C -> snoop_cmd=1, mem_req_we=1, mem_req_write=0x3C; mem_req_valid held 3 cycles while mem_req_ready=0.
- Round-robin: all 4 cores valid continuously -> grant order 0,1,2,3,0; no core granted twice before the others.
- Same-cycle accept+response in ISSUE: mem_req_ready=1 with mem_resp_valid=1 and data 0x5A -> resp_valid exactly 3 cycles after accept.
- Timeout: memory accepts but never responds -> resp_valid with resp_err=1 and data 0x00 after 255 WAIT cycles; next request is served normally.
- Async reset asserted during WAIT -> all outputs 0 immediately, no response; after release, core 0 wins when cores 0 and 3 both request.
